// File: rtl/instr_dispatch_ctrl.sv
// Instruction sequencer: fetch/decode/issue/wait/retire loop with PC control,
// watchdog timeout, illegal-opcode trap and sticky halt/error states.
module instr_dispatch_ctrl #(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [15:0]      mem_data,
    input  logic             mem_valid,
    output logic             mem_rd,
    output logic [15:0]      ir_out,
    output logic             alu_start,
    output logic             mov_start,
    output logic             ldi_start,
    input  logic             alu_done,
    input  logic             mov_done,
    input  logic             ldi_done,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [7:0]       pc_target,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StIssue, StWait, StRetire, StJump, StHalt, StError
    } state_e;

    localparam logic [7:0] TMax = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] timer_q;
    logic [3:0] opcode;
    logic       is_alu, is_mov, is_ldi;
    logic       sel_done, other_done;

    // ir_out is stable from DECODE through RETIRE, so the unit class decodes from it directly.
    assign opcode = ir_out[15:12];
    assign is_mov = (opcode >= 4'd1) && (opcode <= 4'd3);
    assign is_ldi = (opcode == 4'd4);
    assign is_alu = (opcode >= 4'd9);

    assign sel_done   = (is_alu & alu_done) | (is_mov & mov_done) | (is_ldi & ldi_done);
    assign other_done = (~is_alu & alu_done) | (~is_mov & mov_done) | (~is_ldi & ldi_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= 8'd0;
            ir_out      <= 16'd0;
            err_code    <= 2'b00;
            instr_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        state_q <= StFetch;
                        timer_q <= 8'd0;
                    end
                end
                StFetch: begin
                    if (mem_valid) begin
                        ir_out  <= mem_data;
                        state_q <= StDecode;
                    end else if (timer_q == TMax) begin
                        state_q  <= StError;
                        err_code <= 2'b11;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StDecode: begin
                    case (opcode)
                        4'b0000:          state_q <= StRetire;
                        4'b0101:          state_q <= StJump;
                        4'b0110:          state_q <= StHalt;
                        4'b0111, 4'b1000: begin
                            state_q  <= StError;
                            err_code <= 2'b01;
                        end
                        default:          state_q <= StIssue;
                    endcase
                end
                StIssue: begin
                    state_q <= StWait;
                    timer_q <= 8'd0;
                end
                StWait: begin
                    // A stray done from another unit outranks the expected one.
                    if (other_done) begin
                        state_q  <= StError;
                        err_code <= 2'b10;
                    end else if (sel_done) begin
                        state_q <= StRetire;
                    end else if (timer_q == TMax) begin
                        state_q  <= StError;
                        err_code <= 2'b11;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StRetire, StJump: begin
                    instr_count <= instr_count + CNT_W'(1);
                    timer_q     <= 8'd0;
                    state_q     <= run ? StFetch : StIdle;
                end
                StHalt, StError: begin
                    if (clr) begin
                        state_q  <= StIdle;
                        err_code <= 2'b00;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_rd    = (state_q == StFetch);
    assign alu_start = (state_q == StIssue) && is_alu;
    assign mov_start = (state_q == StIssue) && is_mov;
    assign ldi_start = (state_q == StIssue) && is_ldi;
    assign pc_inc    = (state_q == StRetire);
    assign pc_load   = (state_q == StJump);
    assign pc_target = ir_out[7:0];
    assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StIssue) ||
                       (state_q == StWait) || (state_q == StRetire) || (state_q == StJump);
    assign halted    = (state_q == StHalt);
    assign err       = (state_q == StError);

endmodule

// File: doc/instr_dispatch_ctrl.md
Name: instr_dispatch_ctrl

Overview:
Top-level instruction sequencer for the microcontroller datapath. It runs a fetch/decode/dispatch/retire loop over a memory handshake and latches the 16-bit instruction. It hands each instruction to the owning execution FSM (ALU, move, load-immediate) with a start/done handshake, and it owns PC increment and jump. A watchdog timer, illegal-opcode trap and halt state complete the block.

Parameters:
TIMEOUT, 32, maximum cycles spent in WAIT or FETCH before a timeout error (range 2..255)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  clock
rst  input  1  reset
run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
clr  input  1  synchronous pulse; leaves HALT/ERROR to IDLE
mem_data  input  16  instruction word from program memory
mem_valid  input  1  mem_data valid for the current mem_rd
mem_rd  output  1  instruction fetch request
ir_out  output  16  latched instruction, drives execution FSMs
alu_start  output  1  one-cycle start to ALU FSM (opcodes 1001-1111)
mov_start  output  1  one-cycle start to move FSM (opcodes 0001-0011)
ldi_start  output  1  one-cycle start to load-immediate FSM (opcode 0100)
alu_done  input  1  ALU FSM completion pulse
mov_done  input  1  move FSM completion pulse
ldi_done  input  1  load-immediate FSM completion pulse
pc_inc  output  1  one-cycle PC increment
pc_load  output  1  one-cycle PC load (jump)
pc_target  output  8  jump target, equal to ir_out[7:0]
busy  output  1  1 in FETCH, DECODE, ISSUE, WAIT, RETIRE, JUMP
halted  output  1  1 in HALT
err  output  1  1 in ERROR
err_code  output  2  01 illegal opcode, 10 spurious done, 11 timeout; holds until clr/rst
instr_count  output  CNT_W  retired instructions (including jumps)

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk. On reset: state IDLE, ir_out=0, instr_count=0, err_code=00, timer=0, and every strobe/status output is 0.
- The block is a Moore machine. Strobes and status are decoded from the registered state only. err_code, ir_out and instr_count are registers.
- IDLE: run=1 moves to FETCH.
- FETCH: mem_rd=1.
  - On mem_valid: ir_out<=mem_data, go to DECODE.
  - The timer counts FETCH cycles. If timer==TIMEOUT-1 with no mem_valid, go to ERROR with code 11. mem_valid in that same cycle wins.
  - run=0 during FETCH is ignored until the handshake completes.
- DECODE (1 cycle), on ir_out[15:12]:
  - 0000 NOP goes to RETIRE.
  - 0001-0100 and 1001-1111 go to ISSUE.
  - 0101 goes to JUMP.
  - 0110 goes to HALT.
  - 0111 and 1000 go to ERROR with code 01.
- ISSUE (1 cycle): exactly one of alu_start/mov_start/ldi_start is 1, selected by opcode class. Next state WAIT, timer cleared.
- WAIT:
  - Done from the selected unit goes to RETIRE.
  - Done from any non-selected unit goes to ERROR with code 10; this check takes priority over the selected done in the same cycle.
  - timer==TIMEOUT-1 with no done goes to ERROR with code 11. Done in that cycle wins, so at most TIMEOUT WAIT cycles are allowed.
  - Done pulses outside WAIT are ignored.
- RETIRE (1 cycle): pc_inc=1 and instr_count+1, wrapping modulo 2^CNT_W. Then run=1 goes to FETCH, run=0 goes to IDLE.
- JUMP (1 cycle): pc_load=1, pc_target=ir_out[7:0], pc_inc=0, instr_count+1. Then FETCH/IDLE as in RETIRE.
- HALT and ERROR are sticky and only clr or rst leaves them. clr goes to IDLE and clears err_code. clr in other states is ignored.
- Latency with mem_valid returned in the first FETCH cycle:
  - NOP: 3 cycles, FETCH to RETIRE.
  - Jump: 3 cycles.
  - Executed op: 5+k cycles, where k is the number of WAIT cycles before done (k>=0, done seen in the WAIT cycle index k).
- Reset asserted mid-operation aborts immediately. No start or PC strobe may be emitted on the cycle rst falls.
- ir_out is stable from DECODE through RETIRE.

Test Plan:
1. Reset, run=1, mem_valid immediate with 0x9083, alu_done 3 cycles after alu_start -> one alu_start pulse, ir_out=0x9083, no mov/ldi start, one pc_inc, instr_count=1, busy=0 only after run dropped.
2. Three NOPs 0x0000 back-to-back -> pc_inc pulses every 3 cycles, instr_count=3, no start pulses; run=0 after the second -> exactly 2 retire, state IDLE.
3. Jump 0x5042 -> one pc_load with pc_target=0x42, pc_inc never 1, instr_count=1; then 0x1081 -> mov_start, mov_done -> retire.
4. Illegal 0x7000 -> err=1, err_code=01, no starts, held 10 cycles; clr -> IDLE, err_code=00. Spurious ldi_done during ALU WAIT -> err_code=10.
5. TIMEOUT=32, ALU op with no done -> ERROR code 11 after exactly 32 WAIT cycles. Repeat with alu_done at WAIT cycle 31 -> normal retire. mem_valid withheld 32 cycles -> code 11.
6. Halt 0x6000 -> halted=1, no pc_inc, run toggling ignored. Separately, rst mid-WAIT -> all outputs 0, instr_count=0 asynchronously.
